// File: rtl/seg_instruction_fetch.sv
// seg_instruction_fetch: MIPS instruction-fetch stage.
// Holds the PC register, the instruction memory and the IF/ID pipeline register.
// The debug unit uses the load port to write programs into the memory.
// Optional halt detection is enabled by defining SEG_IF_HALT_DETECT_EN.
module seg_instruction_fetch #(
  parameter int               LEN          = 32,
  parameter int               NB_IMEM_ADDR = 10,
  parameter logic [LEN-1:0]   HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_branch_taken,
  input  logic [LEN-1:0]          i_PC_branch,
  input  logic                    i_jump,
  input  logic [LEN-1:0]          i_PC_dir_jump,
  input  logic                    i_imem_we,
  input  logic [NB_IMEM_ADDR-1:0] i_imem_waddr,
  input  logic [LEN-1:0]          i_imem_wdata,
  output logic [LEN-1:0]          o_PC,
  output logic [LEN-1:0]          o_instruction,
  output logic [LEN-1:0]          o_PC_current,
  output logic                    o_halt
);

  localparam int IMEM_DEPTH = 2 ** NB_IMEM_ADDR;

  logic [LEN-1:0] imem [IMEM_DEPTH];

  logic [LEN-1:0] pc_p0;
  logic [LEN-1:0] pc_next;
  logic [LEN-1:0] pc_plus4;
  logic [LEN-1:0] fetch_word;

  logic [LEN-1:0] if_pc_p1;
  logic [LEN-1:0] if_instr_p1;
  logic [LEN-1:0] if_pc_next;
  logic [LEN-1:0] if_instr_next;

  logic           halt_p1;
  logic           halt_hit;

  // Program-load write port; runs even when fetch is disabled or halted
  always_ff @(posedge i_clk) begin
    if (i_imem_we) begin
      imem[i_imem_waddr] <= i_imem_wdata;
    end
  end

  // Word-addressed read; PC byte offset and upper bits are ignored
  assign fetch_word = imem[pc_p0[NB_IMEM_ADDR+1:2]];
  assign pc_plus4   = pc_p0 + LEN'(4);

`ifdef SEG_IF_HALT_DETECT_EN
  // A halt word is recognised only when it would really enter IF/ID
  assign halt_hit = !i_stall && !i_flush && (fetch_word == HALT_WORD);
`else
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;
  assign halt_hit         = 1'b0;
`endif

  // Next PC: halt freezes, then branch over jump over stall over sequential
  always_comb begin
    pc_next = pc_plus4;
    if (halt_p1 || halt_hit) begin
      pc_next = pc_p0;
    end else if (i_branch_taken) begin
      pc_next = i_PC_branch;
    end else if (i_jump) begin
      pc_next = i_PC_dir_jump;
    end else if (i_stall) begin
      pc_next = pc_p0;
    end
  end

  // IF/ID next value: halted drains NOPs, flush beats stall
  always_comb begin
    if_pc_next    = pc_plus4;
    if_instr_next = fetch_word;
    if (halt_p1 || i_flush) begin
      if_instr_next = '0;
    end else if (i_stall) begin
      if_pc_next    = if_pc_p1;
      if_instr_next = if_instr_p1;
    end
  end

  // ---- stage p0: PC register ----
  // PC update, frozen entirely while fetch is disabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_p0 <= '0;
    end else if (i_enable) begin
      pc_p0 <= pc_next;
    end
  end

  // ---- stage p1: IF/ID register ----
  // IF/ID capture of PC+4 and the fetched word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if_pc_p1    <= '0;
      if_instr_p1 <= '0;
    end else if (i_enable) begin
      if_pc_p1    <= if_pc_next;
      if_instr_p1 <= if_instr_next;
    end
  end

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_p1 <= 1'b0;
    end else if (i_enable && halt_hit) begin
      halt_p1 <= 1'b1;
    end
  end

  assign o_PC          = if_pc_p1;
  assign o_instruction = if_instr_p1;
  assign o_PC_current  = pc_p0;
  assign o_halt        = halt_p1;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Directed testbench for seg_instruction_fetch.
// Halt-related expectations follow SEG_IF_HALT_DETECT_EN when it is defined.
module tb_seg_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] pc_branch = '0;
  logic        jump = 1'b0;
  logic [31:0] pc_dir_jump = '0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [31:0] o_pc_cur;
  logic        o_halt;

  int n_assert = 0;
  int n_fail   = 0;

  seg_instruction_fetch dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_branch_taken (branch_taken),
    .i_PC_branch    (pc_branch),
    .i_jump         (jump),
    .i_PC_dir_jump  (pc_dir_jump),
    .i_imem_we      (imem_we),
    .i_imem_waddr   (imem_waddr),
    .i_imem_wdata   (imem_wdata),
    .o_PC           (o_pc),
    .o_instruction  (o_instr),
    .o_PC_current   (o_pc_cur),
    .o_halt         (o_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check PC register and the IF/ID pair together
  task automatic chk_state(input string tag, input logic [31:0] pc_exp,
                           input logic [31:0] ifpc_exp, input logic [31:0] ifins_exp);
    chk({tag, ".pc"},    o_pc_cur, pc_exp);
    chk({tag, ".ifpc"},  o_pc,     ifpc_exp);
    chk({tag, ".ifins"}, o_instr,  ifins_exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    step();
    imem_we    = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_state("reset", 32'h0, 32'h0, 32'h0);
    chk("reset.halt", {31'h0, o_halt}, 32'h0);
    rst = 1'b0;

    // Program load while fetch is disabled
    wr(10'd0,    32'h2001_0005);
    wr(10'd1,    32'h2002_0007);
    wr(10'd2,    32'h0022_1820);
    wr(10'd3,    32'hFFFF_FFFF);
    wr(10'd16,   32'h8C02_0010);
    wr(10'd64,   32'hAC01_0040);
    wr(10'd1023, 32'h1234_5678);
    chk_state("load_disabled", 32'h0, 32'h0, 32'h0);

    // Sequential fetch
    enable = 1'b1;
    step();
    chk_state("seq0", 32'h4, 32'h4, 32'h2001_0005);
    step();
    chk_state("seq1", 32'h8, 32'h8, 32'h2002_0007);

    // Stall two cycles at pc=8
    stall = 1'b1;
    step();
    chk_state("stall0", 32'h8, 32'h8, 32'h2002_0007);
    step();
    chk_state("stall1", 32'h8, 32'h8, 32'h2002_0007);
    stall = 1'b0;
    step();
    chk_state("resume", 32'hC, 32'hC, 32'h0022_1820);

    // Branch + jump + stall: branch wins, IF/ID held by stall
    branch_taken = 1'b1; pc_branch = 32'h40;
    jump = 1'b1; pc_dir_jump = 32'h80;
    stall = 1'b1;
    step();
    chk_state("redir", 32'h40, 32'hC, 32'h0022_1820);
    // Same with flush: IF/ID becomes {pc+4, NOP}
    flush = 1'b1;
    step();
    chk_state("redir_flush", 32'h40, 32'h44, 32'h0);
    branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;

    // Jump to 0x100
    pc_dir_jump = 32'h100;
    step();
    chk_state("jump", 32'h100, 32'h44, 32'h8C02_0010);
    jump = 1'b0;
    step();
    chk_state("jump_fetch", 32'h104, 32'h104, 32'hAC01_0040);

    // Disabled for 3 cycles with other controls active; load port still works
    enable = 1'b0;
    branch_taken = 1'b1; pc_branch = 32'h0;
    flush = 1'b1;
    wr(10'd65, 32'h1111_1111);
    chk_state("dis0", 32'h104, 32'h104, 32'hAC01_0040);
    step();
    chk_state("dis1", 32'h104, 32'h104, 32'hAC01_0040);
    step();
    chk_state("dis2", 32'h104, 32'h104, 32'hAC01_0040);
    flush = 1'b0;

    // Branch to the last word, then wrap to 0
    enable = 1'b1;
    pc_branch = 32'hFFFF_FFFC;
    step();
    chk_state("br_top", 32'hFFFF_FFFC, 32'h108, 32'h1111_1111);
    branch_taken = 1'b0;
    step();
    chk_state("wrap", 32'h0, 32'h0, 32'h1234_5678);

    // Same-cycle write to fetched address: old word captured, new word next time
    wr(10'd0, 32'h2222_2222);
    chk_state("wr_same", 32'h4, 32'h4, 32'h2001_0005);
    branch_taken = 1'b1; pc_branch = 32'h0;
    step();
    chk_state("back0", 32'h0, 32'h8, 32'h2002_0007);
    branch_taken = 1'b0;
    step();
    chk_state("new_word", 32'h4, 32'h4, 32'h2222_2222);

    // Run into the halt word at address 12
    step();
    chk_state("pre_halt8", 32'h8, 32'h8, 32'h2002_0007);
    step();
    chk_state("pre_halt12", 32'hC, 32'hC, 32'h0022_1820);
    chk("pre_halt.halt", {31'h0, o_halt}, 32'h0);
    step();
`ifdef SEG_IF_HALT_DETECT_EN
    chk_state("halt_edge", 32'hC, 32'h10, 32'hFFFF_FFFF);
    chk("halt_edge.halt", {31'h0, o_halt}, 32'h1);
    branch_taken = 1'b1; pc_branch = 32'h40;
    step();
    chk_state("halt_drain0", 32'hC, 32'h10, 32'h0);
    chk("halt_drain0.halt", {31'h0, o_halt}, 32'h1);
    branch_taken = 1'b0;
    step();
    chk_state("halt_drain1", 32'hC, 32'h10, 32'h0);
`else
    chk_state("nohalt_edge", 32'h10, 32'h10, 32'hFFFF_FFFF);
    chk("nohalt_edge.halt", {31'h0, o_halt}, 32'h0);
    step();
    chk("nohalt_next.pc", o_pc_cur, 32'h14);
    chk("nohalt_next.halt", {31'h0, o_halt}, 32'h0);
`endif

    // Asynchronous reset mid-operation, no clock edge needed
    rst = 1'b1;
    #2;
    chk_state("async_rst", 32'h0, 32'h0, 32'h0);
    chk("async_rst.halt", {31'h0, o_halt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
